instruction_decode_stage: RTL and testbench

- Registered decode stage between instruction fetch and execute.
- Accepts 32-bit RV32I instruction words with their PC over a valid/ready handshake.
- Produces execute-side control fields: ALU operation encoding (alu_operation_t), register indices, immediate and operand selects.
- 2-entry skid buffer gives full throughput under backpressure. Covers OP, OP-IMM, LUI and AUIPC; every other opcode is flagged illegal.

---
 rtl/alu_operations.sv | 21 ++
 rtl/decode_types.sv | 30 +++
 rtl/instruction_decoder.sv | 99 +++++++++
 rtl/instruction_decode_stage.sv | 94 +++++++++
 tb/tb_instruction_decode_stage.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_operations.sv
// ALU operation encoding shared by the decode stage and the execute unit.
`default_nettype none

package alu_operations;

  typedef enum logic [3:0] {
    Add                    = 4'd0,
    Subtract               = 4'd1,
    Shift_Left_Logical     = 4'd2,
    Set_Less_Than          = 4'd3,
    Set_Less_Than_Unsigned = 4'd4,
    Xor                    = 4'd5,
    Shift_Right_Logical    = 4'd6,
    Shift_Right_Arithmetic = 4'd7,
    Or                     = 4'd8,
    And                    = 4'd9
  } alu_operation_t;

endpackage

`default_nettype wire

// File: rtl/decode_types.sv
// RV32I opcode/funct7 constants and the decoded-instruction bundle.
`default_nettype none

package decode_types;

  import alu_operations::*;

  localparam logic [6:0] OPCODE_OP     = 7'b0110011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

  localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
  localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_operation_t operation;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [31:0]    immediate;
    logic           operand_1_is_pc;
    logic           operand_2_is_immediate;
    logic           register_write;
    logic           illegal;
  } decoded_instruction_t;

endpackage

`default_nettype wire

// File: rtl/instruction_decoder.sv
// Combinational RV32I decoder for OP, OP-IMM, LUI and AUIPC; anything else is illegal.
`default_nettype none

module instruction_decoder
  import alu_operations::*;
  import decode_types::*;
(
  input  logic [31:0]          i_instruction,
  output decoded_instruction_t o_decoded
);

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic [6:0] w_funct7;
  logic [4:0] w_shamt;
  logic       w_illegal;
  decoded_instruction_t w_dec;

  assign w_opcode = i_instruction[6:0];
  assign w_funct3 = i_instruction[14:12];
  assign w_funct7 = i_instruction[31:25];
  assign w_shamt  = i_instruction[24:20];

  always_comb begin
    w_illegal                    = 1'b0;
    w_dec                        = '0;
    w_dec.operation              = Add;
    w_dec.rd                     = i_instruction[11:7];
    w_dec.rs1                    = i_instruction[19:15];
    w_dec.rs2                    = 5'd0;

    case (w_opcode)
      OPCODE_OP: begin
        w_dec.rs2            = i_instruction[24:20];
        w_dec.register_write = 1'b1;
        case ({w_funct7, w_funct3})
          {FUNCT7_BASE, 3'b000}: w_dec.operation = Add;
          {FUNCT7_ALT,  3'b000}: w_dec.operation = Subtract;
          {FUNCT7_BASE, 3'b001}: w_dec.operation = Shift_Left_Logical;
          {FUNCT7_BASE, 3'b010}: w_dec.operation = Set_Less_Than;
          {FUNCT7_BASE, 3'b011}: w_dec.operation = Set_Less_Than_Unsigned;
          {FUNCT7_BASE, 3'b100}: w_dec.operation = Xor;
          {FUNCT7_BASE, 3'b101}: w_dec.operation = Shift_Right_Logical;
          {FUNCT7_ALT,  3'b101}: w_dec.operation = Shift_Right_Arithmetic;
          {FUNCT7_BASE, 3'b110}: w_dec.operation = Or;
          {FUNCT7_BASE, 3'b111}: w_dec.operation = And;
          default:               w_illegal       = 1'b1;
        endcase
      end
      OPCODE_OP_IMM: begin
        w_dec.operand_2_is_immediate = 1'b1;
        w_dec.register_write         = 1'b1;
        w_dec.immediate              = {{20{i_instruction[31]}}, i_instruction[31:20]};
        case (w_funct3)
          3'b000: w_dec.operation = Add;
          3'b010: w_dec.operation = Set_Less_Than;
          3'b011: w_dec.operation = Set_Less_Than_Unsigned;
          3'b100: w_dec.operation = Xor;
          3'b110: w_dec.operation = Or;
          3'b111: w_dec.operation = And;
          3'b001: begin
            w_dec.immediate = {27'd0, w_shamt};
            if (w_funct7 == FUNCT7_BASE) w_dec.operation = Shift_Left_Logical;
            else                         w_illegal       = 1'b1;
          end
          default: begin
            w_dec.immediate = {27'd0, w_shamt};
            if (w_funct7 == FUNCT7_BASE)     w_dec.operation = Shift_Right_Logical;
            else if (w_funct7 == FUNCT7_ALT) w_dec.operation = Shift_Right_Arithmetic;
            else                             w_illegal       = 1'b1;
          end
        endcase
      end
      OPCODE_LUI, OPCODE_AUIPC: begin
        w_dec.rs1                    = 5'd0;
        w_dec.immediate              = {i_instruction[31:12], 12'd0};
        w_dec.operand_2_is_immediate = 1'b1;
        w_dec.operand_1_is_pc        = (w_opcode == OPCODE_AUIPC);
        w_dec.register_write         = 1'b1;
      end
      default: w_illegal = 1'b1;
    endcase

    // Illegal words must reach execute as a harmless no-write Add.
    if (w_illegal) begin
      w_dec.operation              = Add;
      w_dec.immediate              = 32'd0;
      w_dec.operand_1_is_pc        = 1'b0;
      w_dec.operand_2_is_immediate = 1'b0;
      w_dec.register_write         = 1'b0;
      w_dec.illegal                = 1'b1;
    end
  end

  assign o_decoded = w_dec;

endmodule

`default_nettype wire

// File: rtl/instruction_decode_stage.sv
// Registered RV32I decode stage with a 2-entry skid buffer between fetch and execute.
`default_nettype none

module instruction_decode_stage
  import alu_operations::*;
  import decode_types::*;
#(
  parameter int PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [31:0]         in_instruction,
  input  logic [PC_WIDTH-1:0] in_pc,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output alu_operation_t      out_operation,
  output logic [4:0]          out_rs1,
  output logic [4:0]          out_rs2,
  output logic [4:0]          out_rd,
  output logic [31:0]         out_immediate,
  output logic                out_operand_1_is_pc,
  output logic                out_operand_2_is_immediate,
  output logic                out_register_write,
  output logic                out_illegal
);

  decoded_instruction_t w_decoded;

  decoded_instruction_t r_dec0;
  decoded_instruction_t r_dec1;
  logic [PC_WIDTH-1:0]  r_pc0;
  logic [PC_WIDTH-1:0]  r_pc1;
  logic                 r_valid0;
  logic                 r_valid1;

  logic w_in_fire;
  logic w_out_fire;

  instruction_decoder u_decoder (
    .i_instruction (in_instruction),
    .o_decoded     (w_decoded)
  );

  // Readiness depends only on skid occupancy, never on out_ready.
  assign in_ready   = !r_valid1 && !reset;
  assign out_valid  = r_valid0 && !reset;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid0 <= 1'b0;
      r_valid1 <= 1'b0;
      r_dec0   <= '0;
      r_dec1   <= '0;
      r_pc0    <= '0;
      r_pc1    <= '0;
    end else if (w_out_fire || !r_valid0) begin
      if (r_valid1) begin
        r_dec0   <= r_dec1;
        r_pc0    <= r_pc1;
        r_valid0 <= 1'b1;
        r_valid1 <= 1'b0;
      end else if (w_in_fire) begin
        r_dec0   <= w_decoded;
        r_pc0    <= in_pc;
        r_valid0 <= 1'b1;
      end else begin
        r_valid0 <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_dec1   <= w_decoded;
      r_pc1    <= in_pc;
      r_valid1 <= 1'b1;
    end
  end

  assign out_pc                     = r_pc0;
  assign out_operation              = r_dec0.operation;
  assign out_rs1                    = r_dec0.rs1;
  assign out_rs2                    = r_dec0.rs2;
  assign out_rd                     = r_dec0.rd;
  assign out_immediate              = r_dec0.immediate;
  assign out_operand_1_is_pc        = r_dec0.operand_1_is_pc;
  assign out_operand_2_is_immediate = r_dec0.operand_2_is_immediate;
  assign out_register_write         = r_dec0.register_write;
  assign out_illegal                = r_dec0.illegal;

endmodule

`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
// Directed table-driven bench for instruction_decode_stage plus backpressure and reset sequences.
`default_nettype none

module tb_instruction_decode_stage;
  import alu_operations::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    in_instruction;
  logic [31:0]    in_pc;
  logic           out_valid;
  logic           out_ready;
  logic [31:0]    out_pc;
  alu_operation_t out_operation;
  logic [4:0]     out_rs1;
  logic [4:0]     out_rs2;
  logic [4:0]     out_rd;
  logic [31:0]    out_immediate;
  logic           out_operand_1_is_pc;
  logic           out_operand_2_is_immediate;
  logic           out_register_write;
  logic           out_illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clock = ~clock;

  instruction_decode_stage #(.PC_WIDTH(32)) dut (
    .clock                      (clock),
    .reset                      (reset),
    .in_valid                   (in_valid),
    .in_ready                   (in_ready),
    .in_instruction             (in_instruction),
    .in_pc                      (in_pc),
    .out_valid                  (out_valid),
    .out_ready                  (out_ready),
    .out_pc                     (out_pc),
    .out_operation              (out_operation),
    .out_rs1                    (out_rs1),
    .out_rs2                    (out_rs2),
    .out_rd                     (out_rd),
    .out_immediate              (out_immediate),
    .out_operand_1_is_pc        (out_operand_1_is_pc),
    .out_operand_2_is_immediate (out_operand_2_is_immediate),
    .out_register_write         (out_register_write),
    .out_illegal                (out_illegal)
  );

  typedef struct packed {
    logic [31:0]    instr;
    logic [31:0]    pc;
    alu_operation_t op;
    logic [4:0]     rs1;
    logic [4:0]     rs2;
    logic [4:0]     rd;
    logic [31:0]    imm;
    logic           op1pc;
    logic           op2imm;
    logic           regw;
    logic           illegal;
    logic           chk_idx;
  } vector_t;

  localparam int NV = 14;
  vector_t vec [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_vec(input int i);
    check($sformatf("v%0d_valid", i), {31'd0, out_valid}, 32'd1);
    check($sformatf("v%0d_pc", i), out_pc, vec[i].pc);
    check($sformatf("v%0d_op", i), {28'd0, out_operation}, {28'd0, vec[i].op});
    check($sformatf("v%0d_imm", i), out_immediate, vec[i].imm);
    check($sformatf("v%0d_op1pc", i), {31'd0, out_operand_1_is_pc}, {31'd0, vec[i].op1pc});
    check($sformatf("v%0d_op2imm", i), {31'd0, out_operand_2_is_immediate}, {31'd0, vec[i].op2imm});
    check($sformatf("v%0d_regw", i), {31'd0, out_register_write}, {31'd0, vec[i].regw});
    check($sformatf("v%0d_illegal", i), {31'd0, out_illegal}, {31'd0, vec[i].illegal});
    if (vec[i].chk_idx) begin
      check($sformatf("v%0d_rs1", i), {27'd0, out_rs1}, {27'd0, vec[i].rs1});
      check($sformatf("v%0d_rs2", i), {27'd0, out_rs2}, {27'd0, vec[i].rs2});
      check($sformatf("v%0d_rd", i), {27'd0, out_rd}, {27'd0, vec[i].rd});
    end
  endtask

  task automatic drive(input logic v, input int i);
    in_valid       = v;
    in_instruction = vec[i].instr;
    in_pc          = vec[i].pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //            instr         pc            op                       rs1    rs2    rd     imm           o1pc  o2i   rw    ill   idx
    vec[0]  = '{32'h002081B3, 32'h000, Add,                    5'd1,  5'd2,  5'd3,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[1]  = '{32'h402081B3, 32'h004, Subtract,               5'd1,  5'd2,  5'd3,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[2]  = '{32'hFFF00093, 32'h008, Add,                    5'd0,  5'd0,  5'd1,  32'hFFFFFFFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[3]  = '{32'h40435293, 32'h00C, Shift_Right_Arithmetic, 5'd6,  5'd0,  5'd5,  32'h00000004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[4]  = '{32'h123453B7, 32'h100, Add,                    5'd0,  5'd0,  5'd7,  32'h12345000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[5]  = '{32'h12345397, 32'h100, Add,                    5'd0,  5'd0,  5'd7,  32'h12345000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[6]  = '{32'h00000000, 32'h200, Add,                    5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[7]  = '{32'h0200C0B3, 32'h204, Add,                    5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[8]  = '{32'h00C5C533, 32'h208, Xor,                    5'd11, 5'd12, 5'd10, 32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[9]  = '{32'h80013213, 32'h20C, Set_Less_Than_Unsigned, 5'd2,  5'd0,  5'd4,  32'hFFFFF800, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[10] = '{32'h40109093, 32'h210, Add,                    5'd0,  5'd0,  5'd0,  32'h00000000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vec[11] = '{32'h003150B3, 32'h214, Shift_Right_Logical,    5'd2,  5'd3,  5'd1,  32'h00000000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vec[12] = '{32'h7FF46493, 32'h218, Or,                     5'd8,  5'd0,  5'd9,  32'h000007FF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[13] = '{32'h01F19113, 32'h21C, Shift_Left_Logical,     5'd3,  5'd0,  5'd2,  32'h0000001F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_instruction = 32'd0; in_pc = 32'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_op", {28'd0, out_operation}, {28'd0, Add});
    check("rst_rd", {27'd0, out_rd}, 32'd0);
    check("rst_imm", out_immediate, 32'd0);
    check("rst_regw", {31'd0, out_register_write}, 32'd0);
    check("rst_illegal", {31'd0, out_illegal}, 32'd0);
    @(negedge clock); reset = 1'b0; #1;
    check("rst_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Single-instruction decode, execute always ready.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      @(negedge clock); drive(1'b1, i); #1;
      check($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(posedge clock); #1;
      check_vec(i);
    end
    @(negedge clock); in_valid = 1'b0;
    @(posedge clock); #1;
    check("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: A=vec0 B=vec1 C=vec8 sent back to back while execute stalls.
    @(negedge clock); out_ready = 1'b0; drive(1'b1, 0); #1;
    check("bp_A_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    check_vec(0);
    @(negedge clock); drive(1'b1, 1); #1;
    check("bp_B_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    check_vec(0);
    @(negedge clock); drive(1'b1, 8); #1;
    check("bp_C_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(posedge clock); #1;
    check_vec(0);
    @(negedge clock); #1;
    check("bp_C_still_held", {31'd0, in_ready}, 32'd0);
    check("bp_A_stable_pc", out_pc, vec[0].pc);
    out_ready = 1'b1;
    @(posedge clock); #1;
    check_vec(1);
    @(negedge clock); #1;
    check("bp_C_in_ready_back", {31'd0, in_ready}, 32'd1);
    @(posedge clock); #1;
    check_vec(8);
    @(negedge clock); in_valid = 1'b0;
    @(posedge clock); #1;
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // Fill both entries, then reset for one cycle.
    @(negedge clock); out_ready = 1'b0; drive(1'b1, 3);
    @(negedge clock); drive(1'b1, 5);
    @(negedge clock); in_valid = 1'b0; #1;
    check("sk_full_in_ready", {31'd0, in_ready}, 32'd0);
    reset = 1'b1; #1;
    check("sk_rst_no_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock); #1;
    check("sk_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("sk_rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("sk_rst_pc", out_pc, 32'd0);
    check("sk_rst_imm", out_immediate, 32'd0);
    check("sk_rst_rd", {27'd0, out_rd}, 32'd0);
    check("sk_rst_op1pc", {31'd0, out_operand_1_is_pc}, 32'd0);
    check("sk_rst_regw", {31'd0, out_register_write}, 32'd0);
    @(negedge clock); reset = 1'b0; out_ready = 1'b1; #1;
    check("sk_post_in_ready", {31'd0, in_ready}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      check($sformatf("sk_no_stale_%0d", c), {31'd0, out_valid}, 32'd0);
    end
    @(negedge clock); drive(1'b1, 12);
    @(posedge clock); #1;
    check_vec(12);
    @(negedge clock); in_valid = 1'b0;
    @(posedge clock); #1;
    check("final_empty", {31'd0, out_valid}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
